// File: rtl/generation_scheduler.sv
// Generation sequencer: paces Life generations by render frames, starts life_logic,
// and swaps the double buffer only on a frame boundary. Includes a RUN watchdog.
module generation_scheduler #(
  parameter int PERIOD_W       = 4,
  parameter int GEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 2**22
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [PERIOD_W-1:0] period_in,
  input  logic                pause_in,
  input  logic                step_in,
  input  logic                render_done_in,
  input  logic                logic_done_in,
  input  logic                buf_ready_in,
  output logic                logic_start_out,
  output logic                buf_swap_out,
  output logic [GEN_W-1:0]    gen_count_out,
  output logic                busy_out,
  output logic                timeout_out
);

  localparam int FC_W = PERIOD_W + 1;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_READY, S_START, S_RUN, S_WAIT_FRAME, S_SWAP
  } state_t;

  state_t            state_q, state_d;
  logic [FC_W-1:0]   frame_q, frame_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [GEN_W-1:0]  gen_q, gen_d;
  logic              timeout_q, timeout_d;
  logic              start_q, swap_q, busy_q;

  // One extra bit so the "frames seen >= period+1" compare cannot overflow.
  logic [FC_W:0]     frame_inc, target;
  logic [FC_W-1:0]   frame_sat;

  assign frame_inc = {1'b0, frame_q} + (FC_W+1)'(1);
  assign target    = {2'b00, period_in} + (FC_W+1)'(1);
  assign frame_sat = frame_inc[FC_W] ? {FC_W{1'b1}} : frame_inc[FC_W-1:0];

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (pause_in) begin
          frame_d = '0;
          if (step_in) state_d = S_WAIT_READY;
        end else if (render_done_in) begin
          if (frame_inc >= target) begin
            frame_d = '0;
            state_d = S_WAIT_READY;
          end else begin
            frame_d = frame_sat;
          end
        end
      end
      S_WAIT_READY: if (buf_ready_in) state_d = S_START;
      S_START: begin
        wd_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (logic_done_in) begin
          state_d = render_done_in ? S_SWAP : S_WAIT_FRAME;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_WAIT_FRAME: if (render_done_in) state_d = S_SWAP;
      S_SWAP: begin
        frame_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    gen_d = (state_d == S_SWAP) ? gen_q + GEN_W'(1) : gen_q;
  end

  // Pulse outputs are registered from next state so they align with the state itself.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      wd_q      <= '0;
      gen_q     <= '0;
      timeout_q <= 1'b0;
      start_q   <= 1'b0;
      swap_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      wd_q      <= wd_d;
      gen_q     <= gen_d;
      timeout_q <= timeout_d;
      start_q   <= (state_d == S_START);
      swap_q    <= (state_d == S_SWAP);
      busy_q    <= (state_d != S_IDLE);
    end
  end

  assign logic_start_out = start_q;
  assign buf_swap_out    = swap_q;
  assign gen_count_out   = gen_q;
  assign busy_out        = busy_q;
  assign timeout_out     = timeout_q;

endmodule

// File: tb/tb_generation_scheduler.sv
// Randomized bench: a frame/generation reference model predicts start and swap
// pulses into a queue; a monitor pops and compares whenever the DUT pulses.
module tb_generation_scheduler;
  localparam int PW = 4;
  localparam int GW = 16;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] period_in;
  logic          pause_in, step_in, render_done_in, logic_done_in, buf_ready_in;
  logic          logic_start_out, buf_swap_out, busy_out, timeout_out;
  logic [GW-1:0] gen_count_out;

  generation_scheduler #(.PERIOD_W(PW), .GEN_W(GW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk), .rst_in(rst), .period_in(period_in), .pause_in(pause_in),
    .step_in(step_in), .render_done_in(render_done_in), .logic_done_in(logic_done_in),
    .buf_ready_in(buf_ready_in), .logic_start_out(logic_start_out),
    .buf_swap_out(buf_swap_out), .gen_count_out(gen_count_out),
    .busy_out(busy_out), .timeout_out(timeout_out));

  always #5 clk = ~clk;

  typedef struct { int kind; int cyc; int gen; } ev_t;  // kind 0 = start, 1 = swap
  ev_t expq[$];

  int tests = 0, fails = 0, cyc = 0;

  // Reference model: where the generation currently is, by phase name.
  localparam int P_IDLE = 0, P_NEED_BUF = 1, P_KICK = 2, P_COMPUTE = 3, P_HOLD = 4, P_SHOW = 5;
  int  phase = P_IDLE, frames = 0, run_cycles = 0, gens = 0;
  bit  m_timeout = 0;

  task automatic chk(string name, bit ok, longint act, longint exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    cyc++;
    if (rst) begin
      phase = P_IDLE; frames = 0; run_cycles = 0; gens = 0; m_timeout = 0;
      expq.delete();
      return;
    end
    case (phase)
      P_IDLE: begin
        if (pause_in) begin
          frames = 0;
          if (step_in) phase = P_NEED_BUF;
        end else if (render_done_in) begin
          if (frames + 1 >= int'(period_in) + 1) begin
            frames = 0; phase = P_NEED_BUF;
          end else begin
            frames = (frames + 1 > 31) ? 31 : frames + 1;
          end
        end
      end
      P_NEED_BUF: if (buf_ready_in) begin
        phase = P_KICK;
        expq.push_back('{0, cyc, gens});
      end
      P_KICK: begin phase = P_COMPUTE; run_cycles = 0; end
      P_COMPUTE: begin
        if (logic_done_in) begin
          if (render_done_in) begin
            phase = P_SHOW; gens = (gens + 1) % (1 << GW);
            expq.push_back('{1, cyc, gens});
          end else phase = P_HOLD;
        end else begin
          run_cycles++;
          if (run_cycles == TO) begin m_timeout = 1; phase = P_IDLE; end
        end
      end
      P_HOLD: if (render_done_in) begin
        phase = P_SHOW; gens = (gens + 1) % (1 << GW);
        expq.push_back('{1, cyc, gens});
      end
      default: begin phase = P_IDLE; frames = 0; end
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: compares on each negedge, away from the active edge.
  ev_t e;
  initial forever begin
    @(negedge clk);
    while (expq.size() != 0 && expq[0].cyc < cyc) begin
      e = expq.pop_front();
      chk(e.kind ? "swap_missing" : "start_missing", 1'b0, 0, e.cyc);
    end
    if (logic_start_out || buf_swap_out) begin
      if (expq.size() == 0) begin
        chk("unexpected_pulse", 1'b0, {buf_swap_out, logic_start_out}, 0);
      end else begin
        e = expq.pop_front();
        chk(buf_swap_out ? "swap_pulse" : "start_pulse",
            e.kind == int'(buf_swap_out) && e.cyc == cyc &&
            (e.kind == 0 || int'(gen_count_out) == e.gen),
            {buf_swap_out, logic_start_out, gen_count_out}, {e.kind[1:0], e.gen[15:0]});
      end
    end
    chk("status", {timeout_out, busy_out, gen_count_out} ==
                  {m_timeout, phase != P_IDLE, gens[15:0]},
        {timeout_out, busy_out, gen_count_out}, {m_timeout, phase != P_IDLE, gens[15:0]});
  end

  // rd_gap>0: periodic render pulses; 0: random. ld_delay>0: done that many cycles
  // after the observed start; 0: random done pulses; <0: never done.
  task automatic seg(int n, int per, bit pau, int rd_gap, int ld_delay, int step_pct, int rdy_pct);
    int ld_cnt = -1;
    period_in = per[PW-1:0];
    pause_in  = pau;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      render_done_in = (rd_gap > 0) ? ((k % rd_gap) == rd_gap - 1) : ($urandom_range(11) == 0);
      step_in        = $urandom_range(99) < step_pct;
      buf_ready_in   = $urandom_range(99) < rdy_pct;
      if (ld_cnt > 0) ld_cnt--; else if (ld_cnt == 0) ld_cnt = -1;
      if (logic_start_out) ld_cnt = ld_delay;
      if (ld_delay > 0)       logic_done_in = (ld_cnt == 0);
      else if (ld_delay == 0) logic_done_in = ($urandom_range(9) == 0);
      else                    logic_done_in = 1'b0;
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs",
           {logic_start_out, buf_swap_out, busy_out, timeout_out, gen_count_out} == '0,
           {logic_start_out, buf_swap_out, busy_out, timeout_out, gen_count_out}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; period_in = '0; pause_in = 1'b0; step_in = 1'b0;
    render_done_in = 1'b0; logic_done_in = 1'b0; buf_ready_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {logic_start_out, buf_swap_out, busy_out, timeout_out, gen_count_out} == '0,
        {logic_start_out, buf_swap_out, busy_out, timeout_out, gen_count_out}, 0);
    rst = 1'b0;

    seg(600, 0, 0, 100, 20, 0, 100);   // one generation per two frames
    seg(500, 3, 0, 23, 5, 0, 100);     // period 3
    seg(60, 1, 0, 23, 5, 0, 100);      // period lowered mid-count
    seg(200, 2, 1, 10, 8, 0, 100);     // paused: nothing starts
    seg(300, 2, 1, 10, 8, 3, 100);     // paused with step pulses, some during RUN
    seg(400, 0, 0, 30, 28, 0, 100);    // logic_done coincident with render_done
    seg(400, 0, 0, 15, 6, 0, 3);       // buf_ready mostly low
    for (int i = 0; i < 12; i++)
      seg($urandom_range(150, 400), $urandom_range(0, 15), $urandom_range(3) == 0,
          ($urandom_range(1) == 0) ? 0 : $urandom_range(5, 40), $urandom_range(0, 40),
          $urandom_range(0, 10), $urandom_range(30, 100));
    seg(300, 0, 0, 20, -1, 0, 100);    // logic never finishes: watchdog fires
    async_reset();
    seg(25, 0, 0, 10, -1, 0, 100);     // get into RUN, then reset mid-generation
    async_reset();
    seg(20, 0, 1, 10, -1, 0, 100);
    repeat (4) @(negedge clk);
    chk("queue_drained", expq.size() == 0, expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
